// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline skid buffer.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    localparam int PC_W_DEF    = 32;
    localparam int INSTR_W_DEF = 32;

    localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = '0;

    // Default-width entry; the buffer itself packs {pc, instruction} the same way at any width.
    typedef struct packed {
        logic [PC_W_DEF-1:0]    pc;
        logic [INSTR_W_DEF-1:0] instruction;
    } pipe_entry_t;

endpackage

// File: rtl/pipe_skid_buf_if.sv
// Handshake and payload bundle between an upstream stage, the skid buffer and a downstream stage.
interface pipe_skid_buf_if #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
) ();
    logic               i_flush;
    logic               i_valid;
    logic               o_ready;
    logic [PC_W-1:0]    i_pc;
    logic [INSTR_W-1:0] i_instruction;
    logic               o_valid;
    logic               i_ready;
    logic [PC_W-1:0]    o_pc;
    logic [INSTR_W-1:0] o_instruction;
    logic [1:0]         o_count;

    modport slave (
        input  i_flush, i_valid, i_pc, i_instruction, i_ready,
        output o_ready, o_valid, o_pc, o_instruction, o_count
    );

    modport master (
        output i_flush, i_valid, i_pc, i_instruction, i_ready,
        input  o_ready, o_valid, o_pc, o_instruction, o_count
    );
endinterface

// File: rtl/pipe_entry_reg.sv
// Payload register with synchronous clear and load enable.
module pipe_entry_reg #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end
endmodule

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer carrying {pc, instruction}; all handshake outputs decode from the state register.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int                 PC_W    = 32,
    parameter int                 INSTR_W = 32,
    parameter logic [INSTR_W-1:0] NOP     = INSTR_W'(NOP_INSTR)
) (
    input logic                  clk,
    input logic                  rst,
    pipe_skid_buf_if.slave       bus
);
    localparam int ENTRY_W = PC_W + INSTR_W;

    buf_state_t state_q, state_d;

    logic               accept, drain;
    logic               load_main, load_skid, main_from_skid;
    logic               clear;
    logic [ENTRY_W-1:0] in_entry, main_d, main_q, skid_q;

    assign accept   = bus.i_valid & bus.o_ready;
    assign drain    = bus.o_valid & bus.i_ready;
    assign clear    = rst | bus.i_flush;
    assign in_entry = {bus.i_pc, bus.i_instruction};
    assign main_d   = main_from_skid ? skid_q : in_entry;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (bus.i_flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        load_main = 1'b1;
                        state_d   = HALF;
                    end
                end
                HALF: begin
                    if (accept && drain) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_d   = FULL;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // The skid word moves up to the head; nothing can be accepted here.
                    if (drain) begin
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                        state_d        = HALF;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    pipe_entry_reg #(.W(ENTRY_W)) u_main (
        .clk  (clk),
        .clr  (clear),
        .load (load_main),
        .d    (main_d),
        .q    (main_q)
    );

    pipe_entry_reg #(.W(ENTRY_W)) u_skid (
        .clk  (clk),
        .clr  (clear),
        .load (load_skid),
        .d    (in_entry),
        .q    (skid_q)
    );

    always_comb begin
        bus.o_ready       = (state_q != FULL);
        bus.o_valid       = (state_q != EMPTY);
        bus.o_count       = 2'd0;
        bus.o_pc          = '0;
        bus.o_instruction = NOP;
        unique case (state_q)
            HALF:    bus.o_count = 2'd1;
            FULL:    bus.o_count = 2'd2;
            default: bus.o_count = 2'd0;
        endcase
        if (state_q != EMPTY) begin
            bus.o_pc          = main_q[ENTRY_W-1:INSTR_W];
            bus.o_instruction = main_q[INSTR_W-1:0];
        end
    end
endmodule

// File: tb/tb_pipe_skid_buf.sv
// Directed bench for pipe_skid_buf: default widths plus a 16/24-bit instance with a non-zero NOP.
module tb_pipe_skid_buf;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_skid_buf_if #(.PC_W(32), .INSTR_W(32)) bus_a ();
    pipe_skid_buf_if #(.PC_W(16), .INSTR_W(24)) bus_b ();

    pipe_skid_buf #(.PC_W(32), .INSTR_W(32)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    pipe_skid_buf #(.PC_W(16), .INSTR_W(24), .NOP(24'hABCDEF)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_a(input string tag, input logic v, input logic r, input logic [1:0] c,
                            input logic [31:0] pc, input logic [31:0] instr);
        check_eq({tag, ".valid"}, 64'(bus_a.o_valid), 64'(v));
        check_eq({tag, ".ready"}, 64'(bus_a.o_ready), 64'(r));
        check_eq({tag, ".count"}, 64'(bus_a.o_count), 64'(c));
        check_eq({tag, ".pc"}, 64'(bus_a.o_pc), 64'(pc));
        check_eq({tag, ".instr"}, 64'(bus_a.o_instruction), 64'(instr));
    endtask

    task automatic expect_b(input string tag, input logic v, input logic [1:0] c,
                            input logic [15:0] pc, input logic [23:0] instr);
        check_eq({tag, ".valid"}, 64'(bus_b.o_valid), 64'(v));
        check_eq({tag, ".count"}, 64'(bus_b.o_count), 64'(c));
        check_eq({tag, ".pc"}, 64'(bus_b.o_pc), 64'(pc));
        check_eq({tag, ".instr"}, 64'(bus_b.o_instruction), 64'(instr));
    endtask

    task automatic drive_a(input logic v, input logic [31:0] pc, input logic [31:0] instr);
        bus_a.i_valid       = v;
        bus_a.i_pc          = pc;
        bus_a.i_instruction = instr;
    endtask

    task automatic drive_b(input logic v, input logic [15:0] pc, input logic [23:0] instr);
        bus_b.i_valid       = v;
        bus_b.i_pc          = pc;
        bus_b.i_instruction = instr;
    endtask

    initial begin
        rst = 1'b1;
        bus_a.i_flush = 1'b0;
        bus_a.i_ready = 1'b0;
        bus_b.i_flush = 1'b0;
        bus_b.i_ready = 1'b0;
        drive_a(1'b1, 32'd5, 32'd10);
        drive_b(1'b1, 16'd5, 24'd10);

        // Reset held two cycles with a valid word offered
        step();
        expect_a("rst0", 1'b0, 1'b1, 2'd0, 32'd0, 32'd0);
        step();
        expect_a("rst1", 1'b0, 1'b1, 2'd0, 32'd0, 32'd0);
        expect_b("rst1_b", 1'b0, 2'd0, 16'd0, 24'hABCDEF);
        rst = 1'b0;
        drive_a(1'b0, 32'd0, 32'd0);
        drive_b(1'b0, 16'd0, 24'd0);
        step();
        expect_a("post_rst", 1'b0, 1'b1, 2'd0, 32'd0, 32'd0);

        // Streaming at full rate
        bus_a.i_ready = 1'b1;
        drive_a(1'b1, 32'd5, 32'd10);
        step();
        expect_a("stream0", 1'b1, 1'b1, 2'd1, 32'd5, 32'd10);
        drive_a(1'b1, 32'd20, 32'd30);
        step();
        expect_a("stream1", 1'b1, 1'b1, 2'd1, 32'd20, 32'd30);
        drive_a(1'b1, 32'd55, 32'd67);
        step();
        expect_a("stream2", 1'b1, 1'b1, 2'd1, 32'd55, 32'd67);
        drive_a(1'b0, 32'd0, 32'd0);
        step();
        expect_a("stream_end", 1'b0, 1'b1, 2'd0, 32'd0, 32'd0);

        // Backpressure fills both entries, then drains in order
        bus_a.i_ready = 1'b0;
        drive_a(1'b1, 32'd5, 32'd10);
        step();
        expect_a("bp0", 1'b1, 1'b1, 2'd1, 32'd5, 32'd10);
        drive_a(1'b1, 32'd20, 32'd30);
        step();
        expect_a("bp_full", 1'b1, 1'b0, 2'd2, 32'd5, 32'd10);
        drive_a(1'b0, 32'd0, 32'd0);
        step();
        expect_a("bp_hold", 1'b1, 1'b0, 2'd2, 32'd5, 32'd10);
        bus_a.i_ready = 1'b1;
        step();
        expect_a("bp_drain1", 1'b1, 1'b1, 2'd1, 32'd20, 32'd30);
        step();
        expect_a("bp_drain2", 1'b0, 1'b1, 2'd0, 32'd0, 32'd0);

        // Flush from FULL discards held words and the same-cycle input
        bus_a.i_ready = 1'b0;
        drive_a(1'b1, 32'd7, 32'd9);
        step();
        drive_a(1'b1, 32'd99, 32'd199);
        step();
        expect_a("fl_full", 1'b1, 1'b0, 2'd2, 32'd7, 32'd9);
        bus_a.i_flush = 1'b1;
        drive_a(1'b1, 32'd42, 32'd77);
        step();
        expect_a("fl_empty", 1'b0, 1'b1, 2'd0, 32'd0, 32'd0);
        bus_a.i_flush = 1'b0;
        bus_a.i_ready = 1'b1;
        drive_a(1'b0, 32'd0, 32'd0);
        step();
        expect_a("fl_no42", 1'b0, 1'b1, 2'd0, 32'd0, 32'd0);

        // Accept and drain together in HALF
        bus_a.i_ready = 1'b0;
        drive_a(1'b1, 32'd5, 32'd10);
        step();
        expect_a("sim_half", 1'b1, 1'b1, 2'd1, 32'd5, 32'd10);
        bus_a.i_ready = 1'b1;
        drive_a(1'b1, 32'd20, 32'd30);
        step();
        expect_a("sim_swap", 1'b1, 1'b1, 2'd1, 32'd20, 32'd30);
        drive_a(1'b0, 32'd0, 32'd0);
        step();
        expect_a("sim_end", 1'b0, 1'b1, 2'd0, 32'd0, 32'd0);

        // Reset mid-burst from FULL
        bus_a.i_ready = 1'b0;
        drive_a(1'b1, 32'd1, 32'd2);
        step();
        drive_a(1'b1, 32'd3, 32'd4);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive_a(1'b0, 32'd0, 32'd0);
        expect_a("mid_rst", 1'b0, 1'b1, 2'd0, 32'd0, 32'd0);

        // Narrow instance with non-zero NOP
        step();
        expect_b("b_empty", 1'b0, 2'd0, 16'd0, 24'hABCDEF);
        bus_b.i_ready = 1'b1;
        drive_b(1'b1, 16'h1234, 24'h005678);
        step();
        expect_b("b_s0", 1'b1, 2'd1, 16'h1234, 24'h005678);
        drive_b(1'b1, 16'hBEEF, 24'hC0FFEE);
        step();
        expect_b("b_s1", 1'b1, 2'd1, 16'hBEEF, 24'hC0FFEE);
        drive_b(1'b0, 16'd0, 24'd0);
        step();
        expect_b("b_end", 1'b0, 2'd0, 16'd0, 24'hABCDEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
